// File: rtl/branch_sequencer.sv
// Branch resolution sequencer for KGP-RISC.
// Holds the carry/zero/sign flags, decides taken/not-taken for one branch
// request at a time, redirects the PC and sequences the post-redirect flush.
module branch_sequencer #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              carry,
    input  logic              zero,
    input  logic              sign,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic              branch,
    input  logic              branchType,
    input  logic [1:0]        flag,
    input  logic              brNotEq,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_done,
    output logic              br_taken,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam int unsigned FC_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECIDE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_carry;
    logic                r_zero;
    logic                r_sign;
    logic                r_br_ready;
    logic                r_br_done;
    logic                r_br_taken;
    logic                r_pc_load;
    logic [ADDR_W-1:0]   r_pc_target;
    logic                r_flush;
    logic [FC_W-1:0]     r_fcnt;
    logic [CNT_W-1:0]    r_taken_cnt;

    state_t              w_state_nxt;
    logic                w_br_ready_nxt;
    logic                w_br_done_nxt;
    logic                w_br_taken_nxt;
    logic                w_pc_load_nxt;
    logic [ADDR_W-1:0]   w_pc_target_nxt;
    logic                w_flush_nxt;
    logic [FC_W-1:0]     w_fcnt_nxt;
    logic [CNT_W-1:0]    w_taken_cnt_nxt;

    logic                w_accept;
    logic                w_c;
    logic                w_z;
    logic                w_s;
    logic                w_sel;
    logic                w_taken;

    // Architectural flag registers, loaded whenever the ALU result is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_sign  <= 1'b0;
        end else if (flag_we) begin
            r_carry <= carry;
            r_zero  <= zero;
            r_sign  <= sign;
        end
    end

    // Branch condition: a same-cycle flag update is forwarded ahead of the regs
    always_comb begin
        w_accept = br_valid & r_br_ready;
        w_c      = flag_we ? carry : r_carry;
        w_z      = flag_we ? zero  : r_zero;
        w_s      = flag_we ? sign  : r_sign;
        case (flag)
            2'b00:   w_sel = w_c;
            2'b01:   w_sel = w_z;
            2'b10:   w_sel = w_s;
            default: w_sel = 1'b0;
        endcase
        w_taken = branch & (~branchType | (w_sel ^ brNotEq));
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_br_done_nxt   = 1'b0;
        w_br_taken_nxt  = 1'b0;
        w_pc_load_nxt   = 1'b0;
        w_pc_target_nxt = r_pc_target;
        w_flush_nxt     = 1'b0;
        w_fcnt_nxt      = r_fcnt;
        w_taken_cnt_nxt = r_taken_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_br_done_nxt  = 1'b1;
                    w_br_taken_nxt = w_taken;
                    if (w_taken) begin
                        w_pc_load_nxt   = 1'b1;
                        w_pc_target_nxt = br_target;
                        w_taken_cnt_nxt = (&r_taken_cnt) ? r_taken_cnt
                                                         : r_taken_cnt + CNT_W'(1);
                        w_state_nxt     = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                // Only taken decisions park here; the flush window starts next
                w_flush_nxt = 1'b1;
                w_fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
                w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fcnt_nxt  = r_fcnt - FC_W'(1);
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_br_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_br_ready  <= 1'b1;
            r_br_done   <= 1'b0;
            r_br_taken  <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
            r_flush     <= 1'b0;
            r_fcnt      <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_br_ready  <= w_br_ready_nxt;
            r_br_done   <= w_br_done_nxt;
            r_br_taken  <= w_br_taken_nxt;
            r_pc_load   <= w_pc_load_nxt;
            r_pc_target <= w_pc_target_nxt;
            r_flush     <= w_flush_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_taken_cnt <= w_taken_cnt_nxt;
        end
    end

    assign br_ready  = r_br_ready;
    assign br_done   = r_br_done;
    assign br_taken  = r_br_taken;
    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;
    assign flush     = r_flush;
    assign taken_cnt = r_taken_cnt;

endmodule
